// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: DVP camera-bus test-pattern source, RGB565 sent as two bytes per pixel
// with pclk at clk/2 and href/vsync/data launched on pclk falling edges.
module dvp_pattern_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 8,
    parameter int V_FRONT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        pclk,
    output logic        href,
    output logic        vsync,
    output logic [7:0]  camera_data,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic        busy
);
    localparam int LINE = 2 * H_ACTIVE + H_BLANK;
    localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t      state, state_nx;
    logic [15:0] hcnt, vcnt, h_nx, v_nx, lines, x, pix, solid_r;
    logic [1:0]  mode_r;
    logic [2:0]  bar;
    logic        tick, enter, end_line, end_state, href_nx;

    // tick marks the clk on which pclk falls: one pclk period has elapsed
    always_comb begin
        tick      = state != IDLE && pclk;
        enter     = state == IDLE && en;
        lines     = state == VSYNC ? 16'(VSYNC_LINES) : state == VBACK ? 16'(V_BACK) :
                    state == ACTIVE ? 16'(V_ACTIVE) : 16'(V_FRONT);
        end_line  = hcnt == 16'(LINE - 1);
        end_state = end_line && vcnt == lines - 16'd1;
        h_nx      = end_line ? 16'd0 : hcnt + 16'd1;
        v_nx      = end_state ? 16'd0 : end_line ? vcnt + 16'd1 : vcnt;
        state_nx  = state;
        if (enter)
            state_nx = VSYNC;
        else if (tick && end_state)
            state_nx = state == VSYNC ? VBACK : state == VBACK ? ACTIVE :
                       state == ACTIVE ? VFRONT : en ? VSYNC : IDLE;
        x         = h_nx >> 1;
        bar       = 3'(x / BAR_W);
        pix       = mode_r == 2'd0 ? BARS[bar] :
                    mode_r == 2'd1 ? {x[4:0], x[5:0], x[4:0]} :
                    mode_r == 2'd2 ? {16{x[4] ^ v_nx[4] ^ frame_cnt[0]}} : solid_r;
        href_nx   = state_nx == ACTIVE && h_nx < 16'(2 * H_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            pclk        <= 1'b0;
            href        <= 1'b0;
            vsync       <= 1'b0;
            camera_data <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            mode_r      <= '0;
            solid_r     <= '0;
        end else begin
            state       <= state_nx;
            pclk        <= state != IDLE && !pclk;
            frame_start <= state_nx == VSYNC && (state == IDLE || state == VFRONT);
            if (tick) begin
                hcnt        <= h_nx;
                vcnt        <= v_nx;
                href        <= href_nx;
                camera_data <= href_nx ? (h_nx[0] ? pix[7:0] : pix[15:8]) : 8'h00;
            end
            if (enter || tick)
                vsync <= state_nx == VSYNC;
            if (state_nx == VSYNC && state != VSYNC) begin
                mode_r  <= mode;
                solid_r <= solid_rgb;
            end
            if (tick && end_state && state == VFRONT)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: directed pixel table plus hand sequences for timing, stop, reset and wrap.
module tb_dvp_pattern_tx;
    localparam int HA = 32, HB = 4, VA = 4, VS = 2, VB = 1, VF = 1;
    localparam int LINE = 2 * HA + HB;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid = 16'h0;
    logic        pclk, href, vsync, frame_start, busy;
    logic [7:0]  camera_data, frame_cnt;

    logic        rst_s = 1'b1, en_s = 1'b0;
    logic        pclk_s, href_s, vsync_s, fs_s, busy_s;
    logic [7:0]  data_s, fcs;

    dvp_pattern_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
                     .V_BACK(VB), .V_FRONT(VF)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
        .pclk(pclk), .href(href), .vsync(vsync), .camera_data(camera_data),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy));

    dvp_pattern_tx #(.H_ACTIVE(8), .H_BLANK(1), .V_ACTIVE(1), .VSYNC_LINES(1),
                     .V_BACK(1), .V_FRONT(1)) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .mode(2'd0), .solid_rgb(16'h0),
        .pclk(pclk_s), .href(href_s), .vsync(vsync_s), .camera_data(data_s),
        .frame_start(fs_s), .frame_cnt(fcs), .busy(busy_s));

    always #5 clk = ~clk;

    int vectors = 0, errors = 0, fc_exp = 0;
    int cur_line = -1, bidx = 0, hpulses = 0, bad_len = 0, glitch = 0, vs_clks = 0, fs_total = 0;
    logic href_d = 1'b0;
    logic [7:0] cap [VA][2*HA];

    // frame monitor: bytes captured while pclk is high, stats cleared at each frame_start
    always @(negedge clk) begin
        href_d   <= href;
        fs_total <= fs_total + (frame_start ? 1 : 0);
        vs_clks  <= (frame_start ? 0 : vs_clks) + (vsync ? 1 : 0);
        glitch   <= (frame_start ? 0 : glitch) + ((!href && camera_data != 8'h0) ? 1 : 0);
        if (frame_start) begin
            cur_line <= -1;
            hpulses  <= 0;
            bad_len  <= 0;
        end else begin
            if (href && !href_d) begin
                cur_line <= cur_line + 1;
                hpulses  <= hpulses + 1;
                bidx     <= 0;
            end
            if (!href && href_d && bidx != 2 * HA)
                bad_len <= bad_len + 1;
            if (pclk && href && cur_line >= 0 && cur_line < VA && bidx < 2 * HA) begin
                cap[cur_line][bidx] <= camera_data;
                bidx <= bidx + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int n);
        vectors++;
        errors++;
        $display("FAIL %s: condition not reached within %0d clks", nm, n);
    endtask

    task automatic wait_fs(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        timeout(nm, n);
    endtask

    task automatic wait_idle(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        timeout(nm, n);
    endtask

    task automatic wait_line(input int ln, input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (cur_line >= ln && href) return;
        end
        timeout(nm, n);
    endtask

    task automatic wait_vs_low(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!vsync) return;
        end
        timeout(nm, n);
    endtask

    task automatic wait_last_line_done(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (hpulses == VA && !href) return;
        end
        timeout(nm, n);
    endtask

    task automatic one_frame(input logic [1:0] m, input logic [15:0] s);
        @(negedge clk);
        mode = m;
        solid = s;
        en = 1'b1;
        wait_fs(4, "tbl_fs");
        en = 1'b0;
        wait_idle(3000, "tbl_done");
        fc_exp++;
        chk("tbl_frame_cnt", frame_cnt, 32'(8'(fc_exp)));
    endtask

    typedef struct {
        int          frm;
        int          x;
        int          y;
        logic [15:0] pix;
    } vec_t;

    vec_t        tbl [23];
    int          fmode [5];
    logic [15:0] fsolid [5];

    initial begin
        int cur, bad, fs0, k;
        logic seen;
        tbl[0]  = '{0, 0, 0, 16'hFFFF};  tbl[1]  = '{0, 16, 0, 16'h0000};
        tbl[2]  = '{0, 15, 3, 16'hFFFF}; tbl[3]  = '{0, 31, 2, 16'h0000};
        tbl[4]  = '{1, 0, 0, 16'h0000};  tbl[5]  = '{1, 16, 0, 16'hFFFF};
        tbl[6]  = '{1, 17, 1, 16'hFFFF};
        tbl[7]  = '{2, 0, 0, 16'hFFFF};  tbl[8]  = '{2, 4, 1, 16'hFFE0};
        tbl[9]  = '{2, 8, 0, 16'h07FF};  tbl[10] = '{2, 12, 2, 16'h07E0};
        tbl[11] = '{2, 16, 3, 16'hF81F}; tbl[12] = '{2, 20, 0, 16'hF800};
        tbl[13] = '{2, 24, 1, 16'h001F}; tbl[14] = '{2, 31, 3, 16'h0000};
        tbl[15] = '{2, 3, 0, 16'hFFFF};  tbl[16] = '{2, 19, 0, 16'hF81F};
        tbl[17] = '{3, 5, 0, 16'h28A5};  tbl[18] = '{3, 31, 2, 16'hFBFF};
        tbl[19] = '{3, 20, 1, 16'hA294}; tbl[20] = '{3, 0, 0, 16'h0000};
        tbl[21] = '{4, 0, 0, 16'hA55A};  tbl[22] = '{4, 31, 3, 16'hA55A};
        fmode  = '{2, 2, 0, 1, 3};
        fsolid = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hA55A};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_pclk", pclk, 0);
        chk("rst_href", href, 0);
        chk("rst_vsync", vsync, 0);
        chk("rst_data", camera_data, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // first frame, colour bars: start timing, vsync length, line count
        rst = 1'b0;
        @(negedge clk);
        mode = 2'd0;
        en = 1'b1;
        @(negedge clk);
        chk("start_fs", frame_start, 1);
        chk("start_vsync", vsync, 1);
        chk("start_busy", busy, 1);
        chk("start_pclk0", pclk, 0);
        @(negedge clk);
        chk("fs_one_clk", frame_start, 0);
        chk("pclk_first_rise", pclk, 1);
        en = 1'b0;
        wait_vs_low(400, "vsync_fall");
        chk("vsync_clks", vs_clks, 2 * VS * LINE);
        wait_idle(3000, "first_done");
        fc_exp = 1;
        chk("first_frame_cnt", frame_cnt, 1);
        chk("href_pulses", hpulses, VA);
        chk("href_len_bad", bad_len, 0);
        chk("data_when_href_low", glitch, 0);
        chk("idle_outputs", {pclk, href, vsync, camera_data}, 0);
        chk("bar0_bytes", {cap[0][0], cap[0][1]}, 16'hFFFF);
        chk("bar5_bytes", {cap[2][40], cap[2][41]}, 16'hF800);
        chk("last_px_bytes", {cap[3][62], cap[3][63]}, 16'h0000);

        // pixel table, one single frame per configuration
        cur = -1;
        for (int i = 0; i < 23; i++) begin
            if (tbl[i].frm != cur) begin
                cur = tbl[i].frm;
                one_frame(2'(fmode[cur]), fsolid[cur]);
            end
            chk($sformatf("pix_f%0d_x%0d_y%0d", tbl[i].frm, tbl[i].x, tbl[i].y),
                {cap[tbl[i].y][2*tbl[i].x], cap[tbl[i].y][2*tbl[i].x+1]}, tbl[i].pix);
        end

        // mode change mid-frame only takes effect next frame
        @(negedge clk);
        mode = 2'd3;
        solid = 16'h1234;
        en = 1'b1;
        wait_fs(4, "c_fs1");
        wait_line(1, 2000, "c_line1");
        mode = 2'd0;
        solid = 16'hFFFF;
        wait_fs(2000, "c_fs2");
        bad = 0;
        for (int y = 0; y < VA; y++)
            for (int b = 0; b < 2 * HA; b++)
                if (cap[y][b] != ((b % 2 == 1) ? 8'h34 : 8'h12)) bad++;
        chk("solid_frame_bad_bytes", bad, 0);
        en = 1'b0;
        wait_idle(3000, "c_done");
        fc_exp += 2;
        chk("c_frame_cnt", frame_cnt, 32'(8'(fc_exp)));
        chk("c_next_bar0", {cap[0][0], cap[0][1]}, 16'hFFFF);
        chk("c_next_bar5", {cap[1][40], cap[1][41]}, 16'hF800);

        // en dropped mid-frame: full frame, then idle with no restart
        @(negedge clk);
        mode = 2'd1;
        en = 1'b1;
        wait_fs(4, "d_fs");
        wait_line(2, 2000, "d_line2");
        en = 1'b0;
        fs0 = fs_total;
        wait_idle(3000, "d_done");
        fc_exp++;
        chk("d_frame_cnt", frame_cnt, 32'(8'(fc_exp)));
        chk("d_href_pulses", hpulses, VA);
        chk("d_idle_outputs", {pclk, href, vsync, camera_data, frame_start}, 0);
        repeat (300) @(negedge clk);
        chk("d_no_restart", fs_total - fs0, 0);
        chk("d_busy", busy, 0);

        // en re-asserted during front porch of a stopping frame
        @(negedge clk);
        en = 1'b1;
        wait_fs(4, "e_fs");
        wait_line(1, 2000, "e_line1");
        en = 1'b0;
        wait_last_line_done(2000, "e_last_line");
        repeat (20) @(negedge clk);
        chk("e_in_vfront", {busy, vsync, href}, 3'b100);
        en = 1'b1;
        wait_fs(300, "e_restart");
        en = 1'b0;
        wait_idle(3000, "e_done");
        fc_exp += 2;
        chk("e_frame_cnt", frame_cnt, 32'(8'(fc_exp)));

        // reset mid active line
        @(negedge clk);
        mode = 2'd0;
        en = 1'b1;
        wait_fs(4, "f_fs");
        wait_line(1, 2000, "f_line1");
        rst = 1'b1;
        @(negedge clk);
        chk("f_rst_outputs", {pclk, href, vsync, camera_data, frame_start, busy}, 0);
        chk("f_rst_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("f_restart_fs", frame_start, 1);
        chk("f_restart_vsync", vsync, 1);
        wait_vs_low(400, "f_vsync_fall");
        chk("f_vsync_clks", vs_clks, 2 * VS * LINE);
        en = 1'b0;
        wait_idle(3000, "f_done");
        chk("f_frame_cnt", frame_cnt, 1);

        // frame counter wrap on the small instance
        rst_s = 1'b0;
        en_s = 1'b1;
        seen = 1'b0;
        k = 0;
        while (k < 40000 && !(seen && fcs == 8'd0)) begin
            @(negedge clk);
            if (fcs == 8'd255) seen = 1'b1;
            k++;
        end
        chk("wrap_255_to_0", {seen, fcs}, {1'b1, 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
